branch_predict_unit: RTL and testbench

//  Branch unit for the pipelined RV32I/RV64I core. Resolves B-type conditions in EX.

---
 rtl/branch_predict_unit.sv | 131 +++++++++++++
 tb/tb_branch_predict_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolve unit with PC-indexed 2-bit BHT.
// Optional build macro BRANCH_STATS_EN adds branch/mispredict counters.
module branch_predict_unit #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned BHT_IDX_W = 6,
   parameter logic [1:0]  BHT_INIT  = 2'b01
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   input  logic            ex_valid,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_r1,
   input  logic [XLEN-1:0] ex_r2,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   output logic            ex_taken,
   output logic [XLEN-1:0] ex_target,
   output logic            ex_redirect,
   output logic [XLEN-1:0] ex_next_pc,
   output logic            ex_illegal
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int unsigned BhtEntries = 1 << BHT_IDX_W;

   logic [1:0]           bht_q [BhtEntries];
   logic [1:0]           bht_d [BhtEntries];
   logic [BHT_IDX_W-1:0] if_idx;
   logic [BHT_IDX_W-1:0] ex_idx;
   logic                 cond_eq;
   logic                 cond_lt_s;
   logic                 cond_lt_u;
   logic                 cond_met;
   logic                 bht_we;
   logic [1:0]           cnt_old;
   logic [1:0]           cnt_new;
   logic                 unused_if_pc;

   assign if_idx = if_pc[BHT_IDX_W+1:2];
   assign ex_idx = ex_pc[BHT_IDX_W+1:2];

   // Only the index bits of the fetch PC matter; the rest alias freely.
   assign unused_if_pc = ^{if_pc[XLEN-1:BHT_IDX_W+2], if_pc[1:0]};

   assign if_pred_taken = bht_q[if_idx][1];

   // Condition evaluation
   assign cond_eq   = (ex_r1 == ex_r2);
   assign cond_lt_s = ($signed(ex_r1) < $signed(ex_r2));
   assign cond_lt_u = (ex_r1 < ex_r2);

   always_comb begin
      cond_met   = 1'b0;
      ex_illegal = 1'b0;
      case (ex_funct3)
         3'b000:  cond_met = cond_eq;
         3'b001:  cond_met = ~cond_eq;
         3'b100:  cond_met = cond_lt_s;
         3'b101:  cond_met = ~cond_lt_s;
         3'b110:  cond_met = cond_lt_u;
         3'b111:  cond_met = ~cond_lt_u;
         default: ex_illegal = ex_valid;
      endcase
   end

   assign ex_taken    = ex_valid & ~ex_illegal & cond_met;
   assign ex_target   = ex_pc + ex_imm;
   assign ex_next_pc  = ex_taken ? ex_target : (ex_pc + XLEN'(4));
   assign ex_redirect = ex_valid & ~ex_illegal & (ex_taken != ex_pred_taken);

   // Saturating counter update
   assign bht_we  = ex_valid & ~ex_illegal;
   assign cnt_old = bht_q[ex_idx];

   always_comb begin
      cnt_new = cnt_old;
      if (ex_taken) begin
         if (cnt_old != 2'b11) cnt_new = cnt_old + 2'b01;
      end else begin
         if (cnt_old != 2'b00) cnt_new = cnt_old - 2'b01;
      end
   end

   always_comb begin
      bht_d = bht_q;
      if (bht_we) bht_d[ex_idx] = cnt_new;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BhtEntries; i++) bht_q[i] <= BHT_INIT;
      end else begin
         bht_q <= bht_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches_q;
   logic [31:0] stat_branches_d;
   logic [31:0] stat_mispredicts_q;
   logic [31:0] stat_mispredicts_d;

   always_comb begin
      stat_branches_d    = stat_branches_q;
      stat_mispredicts_d = stat_mispredicts_q;
      if (bht_we)      stat_branches_d    = stat_branches_q + 32'd1;
      if (ex_redirect) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_q    <= '0;
         stat_mispredicts_q <= '0;
      end else begin
         stat_branches_q    <= stat_branches_d;
         stat_mispredicts_q <= stat_mispredicts_d;
      end
   end

   assign stat_branches    = stat_branches_q;
   assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: EX vector table plus BHT sequences.
module tb_branch_predict_unit;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        ex_valid;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_r1;
   logic [31:0] ex_r2;
   logic [31:0] ex_pc;
   logic [31:0] ex_imm;
   logic        ex_pred_taken;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_redirect;
   logic [31:0] ex_next_pc;
   logic        ex_illegal;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches;
   logic [31:0] stat_mispredicts;
`endif

   int n_cmp = 0;
   int n_err = 0;

   branch_predict_unit #(
      .XLEN      (32),
      .BHT_IDX_W (6),
      .BHT_INIT  (2'b01)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .if_pc         (if_pc),
      .if_pred_taken (if_pred_taken),
      .ex_valid      (ex_valid),
      .ex_funct3     (ex_funct3),
      .ex_r1         (ex_r1),
      .ex_r2         (ex_r2),
      .ex_pc         (ex_pc),
      .ex_imm        (ex_imm),
      .ex_pred_taken (ex_pred_taken),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_redirect   (ex_redirect),
      .ex_next_pc    (ex_next_pc),
      .ex_illegal    (ex_illegal)
`ifdef BRANCH_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [2:0]  f3;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] pc;
      logic [31:0] imm;
      logic        pred;
      logic        e_taken;
      logic [31:0] e_target;
      logic [31:0] e_next;
      logic        e_redirect;
      logic        e_illegal;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] pc, input logic [31:0] imm,
                        input logic pred);
      ex_valid      = v;
      ex_funct3     = f3;
      ex_r1         = r1;
      ex_r2         = r2;
      ex_pc         = pc;
      ex_imm        = imm;
      ex_pred_taken = pred;
   endtask

   task automatic idle();
      ex_valid = 1'b0;
   endtask

   // One legal update: r1==r2, so beq is taken and bne is not.
   task automatic upd(input logic [31:0] pc, input logic taken);
      drive(1'b1, taken ? 3'b000 : 3'b001, 32'd5, 32'd5, pc, 32'd4, 1'b0);
      tick();
      idle();
   endtask

   task automatic expect_pred(input logic [31:0] pc, input logic exp, input string name);
      if_pc = pc;
      #2;
      check(name, {63'd0, if_pred_taken}, {63'd0, exp});
   endtask

   initial begin
      //             v  f3      r1            r2            pc            imm           pr tk tgt           next          rd il
      vecs[0]  = '{1, 3'b000, 32'd5,        32'd5,        32'h100,      32'h20,       0, 1, 32'h120,      32'h120,      1, 0};
      vecs[1]  = '{1, 3'b001, 32'd5,        32'd5,        32'h200,      32'h10,       0, 0, 32'h210,      32'h204,      0, 0};
      vecs[2]  = '{1, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h8,        1, 1, 32'h8,        32'h8,        0, 0};
      vecs[3]  = '{1, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h8,        1, 0, 32'h8,        32'h4,        1, 0};
      vecs[4]  = '{1, 3'b101, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h8,        0, 0, 32'h8,        32'h4,        0, 0};
      vecs[5]  = '{1, 3'b111, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h8,        0, 1, 32'h8,        32'h8,        1, 0};
      vecs[6]  = '{1, 3'b010, 32'd3,        32'd3,        32'h40,       32'h100,      0, 0, 32'h140,      32'h44,       0, 1};
      vecs[7]  = '{1, 3'b011, 32'd3,        32'd3,        32'h40,       32'h100,      1, 0, 32'h140,      32'h44,       0, 1};
      vecs[8]  = '{0, 3'b000, 32'd7,        32'd7,        32'h300,      32'hFFFFFFF0, 1, 0, 32'h2F0,      32'h304,      0, 0};
      vecs[9]  = '{1, 3'b001, 32'd1,        32'd2,        32'hFFFFFFF0, 32'h20,       0, 1, 32'h10,       32'h10,       1, 0};
      vecs[10] = '{1, 3'b000, 32'd1,        32'd2,        32'hFFFFFFFC, 32'h8,        1, 0, 32'h4,        32'h0,        1, 0};
      vecs[11] = '{1, 3'b101, 32'h80000000, 32'h80000000, 32'h500,      32'h4,        1, 1, 32'h504,      32'h504,      0, 0};

      rst   = 1'b1;
      if_pc = 32'h0;
      drive(1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      expect_pred(32'h100, 1'b0, "reset_pred");
`ifdef BRANCH_STATS_EN
      check("reset_stat_br", {32'd0, stat_branches}, 64'd0);
      check("reset_stat_mp", {32'd0, stat_mispredicts}, 64'd0);
`endif
      tick();
      rst = 1'b0;

      // Combinational EX vectors
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].valid, vecs[i].f3, vecs[i].r1, vecs[i].r2, vecs[i].pc, vecs[i].imm,
               vecs[i].pred);
         #2;
         check($sformatf("vec%0d taken", i), {63'd0, ex_taken}, {63'd0, vecs[i].e_taken});
         check($sformatf("vec%0d target", i), {32'd0, ex_target}, {32'd0, vecs[i].e_target});
         check($sformatf("vec%0d next_pc", i), {32'd0, ex_next_pc}, {32'd0, vecs[i].e_next});
         check($sformatf("vec%0d redirect", i), {63'd0, ex_redirect},
               {63'd0, vecs[i].e_redirect});
         check($sformatf("vec%0d illegal", i), {63'd0, ex_illegal}, {63'd0, vecs[i].e_illegal});
         tick();
      end

      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;

      // Basic mispredict and first update
      if_pc = 32'h100;
      drive(1'b1, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
      #2;
      check("t1_taken", {63'd0, ex_taken}, 64'd1);
      check("t1_target", {32'd0, ex_target}, 64'h120);
      check("t1_next_pc", {32'd0, ex_next_pc}, 64'h120);
      check("t1_redirect", {63'd0, ex_redirect}, 64'd1);
      check("t1_pred_before", {63'd0, if_pred_taken}, 64'd0);
      tick();
      idle();
      expect_pred(32'h100, 1'b1, "t1_pred_after");

      // Saturation and floor at pc=0x40
      for (int k = 0; k < 4; k++) upd(32'h40, 1'b1);
      expect_pred(32'h40, 1'b1, "sat_4taken");
      upd(32'h40, 1'b0);
      expect_pred(32'h40, 1'b1, "sat_1nt");
      upd(32'h40, 1'b0);
      expect_pred(32'h40, 1'b0, "sat_2nt");
      upd(32'h40, 1'b0);
      upd(32'h40, 1'b0);
      upd(32'h40, 1'b1);
      expect_pred(32'h40, 1'b0, "floor_hold");
      upd(32'h40, 1'b1);
      expect_pred(32'h40, 1'b1, "floor_recover");

      // Illegal funct3 and ex_valid=0 must leave entry 0x40 at weak-taken
      drive(1'b1, 3'b010, 32'd3, 32'd3, 32'h40, 32'h100, 1'b1);
      #2;
      check("ill_flag", {63'd0, ex_illegal}, 64'd1);
      check("ill_redirect", {63'd0, ex_redirect}, 64'd0);
      check("ill_taken", {63'd0, ex_taken}, 64'd0);
      tick();
      idle();
      expect_pred(32'h40, 1'b1, "ill_no_update");
      drive(1'b0, 3'b001, 32'd1, 32'd2, 32'h40, 32'h0, 1'b1);
      #2;
      check("inval_taken", {63'd0, ex_taken}, 64'd0);
      check("inval_redirect", {63'd0, ex_redirect}, 64'd0);
      tick();
      idle();
      expect_pred(32'h40, 1'b1, "inval_no_update");

      // Same-cycle read/write returns the old value; aliasing through bits above the index
      if_pc = 32'h8;
      drive(1'b1, 3'b000, 32'd5, 32'd5, 32'h8, 32'd4, 1'b0);
      #2;
      check("hazard_old", {63'd0, if_pred_taken}, 64'd0);
      tick();
      #2;
      check("hazard_new", {63'd0, if_pred_taken}, 64'd1);
      tick();
      idle();
      expect_pred(32'h108, 1'b1, "alias_read");
      expect_pred(32'h10, 1'b0, "alias_other_idx");
      upd(32'h108, 1'b0);
      upd(32'h108, 1'b0);
      expect_pred(32'h8, 1'b0, "alias_write");

      // Reset wins over a same-cycle update
      rst = 1'b1;
      drive(1'b1, 3'b000, 32'd5, 32'd5, 32'h20, 32'd4, 1'b0);
      tick();
      rst = 1'b0;
      idle();
      expect_pred(32'h20, 1'b0, "rst_prio");
      expect_pred(32'h40, 1'b0, "rst_clears");
`ifdef BRANCH_STATS_EN
      check("rst_stat_br", {32'd0, stat_branches}, 64'd0);
      check("rst_stat_mp", {32'd0, stat_mispredicts}, 64'd0);
`endif
      upd(32'h20, 1'b1);
      expect_pred(32'h20, 1'b1, "post_rst_update");
`ifdef BRANCH_STATS_EN
      check("stat_br_1", {32'd0, stat_branches}, 64'd1);
      check("stat_mp_1", {32'd0, stat_mispredicts}, 64'd1);
      dut.stat_branches_q = 32'hFFFFFFFF;
      upd(32'h20, 1'b1);
      #1;
      check("stat_br_wrap", {32'd0, stat_branches}, 64'd0);
      check("stat_mp_2", {32'd0, stat_mispredicts}, 64'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
